// File: rtl/wb_blk_mover_if.sv
// Wishbone classic bus bundle between the block mover (master) and the memory slave.
interface wb_blk_mover_if;
  logic [31:0] adr;
  logic [31:0] dout;
  logic [31:0] din;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, dout, cyc, stb, we, sel,
    input  din, ack, err, rty
  );

  modport slave (
    input  adr, dout, cyc, stb, we, sel,
    output din, ack, err, rty
  );
endinterface

// File: rtl/wb_blk_mover.sv
// Wishbone block mover: copies len words from src to dst through a small chunk
// buffer, alternating read bursts and write bursts, with retry/abort handling.
//
// state | meaning
// IDLE  | waiting for start
// RD    | reading a chunk into the buffer (entered with cyc low after a chunk write)
// TURN  | one bus-idle cycle between read and write phases
// WR    | writing the buffered chunk to the destination
// FIN   | completion cycle; done pulses on the way back to IDLE
module wb_blk_mover #(
  parameter int BUF_DEPTH = 4,
  parameter int MAX_RTY   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           src_adr,
  input  logic [31:0]           dst_adr,
  input  logic [15:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           wcnt,
  wb_blk_mover_if.master        bus
);

  localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int RW = (MAX_RTY > 0) ? $clog2(MAX_RTY + 1) : 1;

  typedef enum logic [2:0] {IDLE, RD, TURN, WR, FIN} state_t;

  state_t        state;
  logic [31:0]   src_ptr;
  logic [31:0]   dst_ptr;
  logic [15:0]   rd_rem;
  logic [CW-1:0] rd_idx;
  logic [CW-1:0] wr_idx;
  logic [RW-1:0] rty_cnt;
  logic [31:0]   buffer [BUF_DEPTH];

  logic [CW-1:0] rd_idx_nx;
  logic [CW-1:0] wr_idx_nx;
  logic          rty_over;
  logic          rd_take;

  assign bus.sel   = 4'hf;
  assign rd_idx_nx = rd_idx + 1'b1;
  assign wr_idx_nx = wr_idx + 1'b1;
  assign rty_over  = (rty_cnt >= RW'(MAX_RTY));
  assign rd_take   = (state == RD) && bus.cyc && bus.stb && bus.ack && !bus.err;

  // Buffer needs no reset: a word is only written back after it was read in this chunk.
  always_ff @(posedge clk) begin
    if (rd_take) buffer[rd_idx[IW-1:0]] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      rd_rem  <= '0;
      rd_idx  <= '0;
      wr_idx  <= '0;
      rty_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      wcnt    <= '0;
      bus.adr <= '0;
      bus.dout <= '0;
      bus.cyc <= 1'b0;
      bus.stb <= 1'b0;
      bus.we  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error   <= 1'b0;
            wcnt    <= '0;
            rd_idx  <= '0;
            wr_idx  <= '0;
            rty_cnt <= '0;
            if (len != 16'd0) begin
              src_ptr <= src_adr & 32'hffff_fffc;
              dst_ptr <= dst_adr & 32'hffff_fffc;
              rd_rem  <= len;
              bus.adr <= src_adr & 32'hffff_fffc;
              bus.cyc <= 1'b1;
              bus.stb <= 1'b1;
              bus.we  <= 1'b0;
              busy    <= 1'b1;
              state   <= RD;
            end else begin
              state <= FIN;
            end
          end
        end

        RD: begin
          if (!bus.cyc) begin
            bus.cyc <= 1'b1;
            bus.stb <= 1'b1;
            bus.we  <= 1'b0;
            bus.adr <= src_ptr;
          end else if (!bus.stb) begin
            bus.stb <= 1'b1;
          end else if (bus.err) begin
            bus.cyc <= 1'b0;
            bus.stb <= 1'b0;
            bus.we  <= 1'b0;
            error   <= 1'b1;
            busy    <= 1'b0;
            rd_idx  <= '0;
            state   <= FIN;
          end else if (bus.ack) begin
            src_ptr <= src_ptr + 32'd4;
            rd_idx  <= rd_idx_nx;
            rd_rem  <= rd_rem - 16'd1;
            rty_cnt <= '0;
            if (rd_idx_nx == CW'(BUF_DEPTH) || rd_rem == 16'd1) begin
              bus.cyc <= 1'b0;
              bus.stb <= 1'b0;
              state   <= TURN;
            end else begin
              bus.adr <= src_ptr + 32'd4;
            end
          end else if (bus.rty) begin
            if (rty_over) begin
              bus.cyc <= 1'b0;
              bus.stb <= 1'b0;
              bus.we  <= 1'b0;
              error   <= 1'b1;
              busy    <= 1'b0;
              rd_idx  <= '0;
              state   <= FIN;
            end else begin
              rty_cnt <= rty_cnt + 1'b1;
              bus.stb <= 1'b0;
            end
          end
        end

        TURN: begin
          bus.cyc  <= 1'b1;
          bus.stb  <= 1'b1;
          bus.we   <= 1'b1;
          bus.adr  <= dst_ptr;
          bus.dout <= buffer[0];
          wr_idx   <= '0;
          state    <= WR;
        end

        WR: begin
          if (!bus.stb) begin
            bus.stb <= 1'b1;
          end else if (bus.err) begin
            bus.cyc <= 1'b0;
            bus.stb <= 1'b0;
            bus.we  <= 1'b0;
            error   <= 1'b1;
            busy    <= 1'b0;
            rd_idx  <= '0;
            state   <= FIN;
          end else if (bus.ack) begin
            dst_ptr <= dst_ptr + 32'd4;
            wcnt    <= wcnt + 16'd1;
            wr_idx  <= wr_idx_nx;
            rty_cnt <= '0;
            if (wr_idx_nx == rd_idx) begin
              // Chunk drained: RD is entered with cyc low to give the idle gap.
              bus.cyc <= 1'b0;
              bus.stb <= 1'b0;
              bus.we  <= 1'b0;
              rd_idx  <= '0;
              if (rd_rem != 16'd0) begin
                state <= RD;
              end else begin
                busy  <= 1'b0;
                state <= FIN;
              end
            end else begin
              bus.adr  <= dst_ptr + 32'd4;
              bus.dout <= buffer[wr_idx_nx[IW-1:0]];
            end
          end else if (bus.rty) begin
            if (rty_over) begin
              bus.cyc <= 1'b0;
              bus.stb <= 1'b0;
              bus.we  <= 1'b0;
              error   <= 1'b1;
              busy    <= 1'b0;
              rd_idx  <= '0;
              state   <= FIN;
            end else begin
              rty_cnt <= rty_cnt + 1'b1;
              bus.stb <= 1'b0;
            end
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_blk_mover.md
WB_BLK_MOVER -- requirements
Module: wb_blk_mover

Interface
REQ-001 Parameter BUF_DEPTH, default 4: words held in the internal chunk buffer (power of two, 1..16).
REQ-002 Parameter MAX_RTY, default 8: retry terminations tolerated per transfer before abort.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 Port src_adr  input  32  source byte address; bits [1:0] ignored, treated as 0.
REQ-007 Port dst_adr  input  32  destination byte address; bits [1:0] ignored, treated as 0.
REQ-008 Port len  input  16  number of 32-bit words to copy.
REQ-009 Port busy  output  1  high from the cycle after an accepted start until done.
REQ-010 Port done  output  1  one-cycle completion pulse, on success or abort.
REQ-011 Port error  output  1  sticky abort flag; cleared by the next accepted start.
REQ-012 Port wcnt  output  16  words successfully written in the current or last copy.
REQ-013 Port adr  output  32  Wishbone address.
REQ-014 Port dout  output  32  Wishbone write data.
REQ-015 Port din  input  32  Wishbone read data.
REQ-016 Ports cyc, stb, we  output  1 each  Wishbone cycle, strobe and write-enable.
REQ-017 Port sel  output  4  byte selects; constant 4'hf.
REQ-018 Ports ack, err, rty  input  1 each  Wishbone slave terminations.

Function
REQ-019 FSM states: IDLE, RD, TURN, WR, FIN; registered state, adr, dout, we, cyc and stb.
REQ-020 IDLE, start=1, len!=0: latch src, dst and len; clear error and wcnt; go to RD.
REQ-021 IDLE, start=1, len=0: go to FIN without any bus activity; error stays 0.
REQ-022 start outside IDLE is ignored.
REQ-023 RD: cyc=stb=1, we=0, adr=src_ptr; on ack, buffer[rd_idx]<=din, src_ptr+=4, rd_idx+=1.
REQ-024 RD ends on the ack that fills BUF_DEPTH words or reads the last remaining word; go to TURN.
REQ-025 TURN: cyc=stb=0 for exactly one cycle, then WR.
REQ-026 WR: cyc=stb=1, we=1, adr=dst_ptr, dout=buffer[wr_idx]; on ack, dst_ptr+=4, wcnt+=1, wr_idx+=1.
REQ-027 WR ends on the ack of the last buffered word: if words remain, one idle cycle (cyc=stb=0) then RD; otherwise FIN.
REQ-028 Within one RD or WR phase, stb stays high across consecutive transfers; adr/dout change only on the cycle after an ack.
REQ-029 rty (no ack): drop stb for one cycle, keep cyc, reissue the same address/data; increment the per-transfer retry count, which resets on every ack.
REQ-030 If the retry count exceeds MAX_RTY, abort.
REQ-031 err: abort; err takes precedence when asserted together with ack or rty.
REQ-032 Abort: cyc=stb=we=0 on the next cycle; error<=1; go to FIN; wcnt keeps its value; partially read buffer contents are discarded.
REQ-033 FIN: done=1 for one cycle; busy=0; go to IDLE.
REQ-034 Address pointers wrap modulo 2^32; no boundary checks.
REQ-035 busy is high in RD, TURN, WR and FIN-entry cycles, and low in IDLE and FIN.

Reset
REQ-036 rst=1 forces immediately, regardless of clk: state=IDLE, cyc=stb=we=0, adr=0, dout=0, busy=0, done=0, error=0, wcnt=0, retry count and indices 0.
REQ-037 rst asserted mid-transfer drops cyc/stb at once; no further bus cycles occur until a new start after reset release.

Verification
REQ-038 Copy 6 words, src 0x100 -> dst 0x400, slave delay 0 -> two chunks (4+2), read data at dst 0x400..0x414 equals src, wcnt=6, error=0, one done pulse.
REQ-039 start with len=0 -> done pulse 2 cycles after start, cyc never asserted, wcnt=0.
REQ-040 len=5, err on the 3rd read -> cyc low next cycle, error=1, wcnt=0, done once, destination untouched.
REQ-041 rty returned twice on the first write, then ack -> copy completes, error=0; with 9 consecutive rty (MAX_RTY=8) -> abort, error=1.
REQ-042 rst pulsed while in WR of a len=8 copy, slave delay 3 -> cyc/stb low within the same cycle; all outputs at reset values; a later start copies correctly.
REQ-043 Slave delay 5, len=4, src 0xFFFF_FFF8 -> addresses wrap to 0x0000_0000; start pulses during busy are ignored.
